// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, ALU, state and field definitions for the processor control slice
// Purpose: constants reused by proc_control_unit, proc_reg_decoder and the bench.
// Ports: none (package).
package proc_pkg;

   // Opcode field iin[15:13]; 011 and 110 are unassigned and retire as illegal.
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_NAN = 3'b010;
   localparam logic [2:0] OP_OUT = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b101;
   localparam logic [2:0] OP_REP = 3'b111;

   // ALU operation select; sub computes A - bus.
   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_NAND = 2'b10;

   // Instruction field bit positions.
   localparam int OPC_HI = 15;
   localparam int OPC_LO = 13;
   localparam int RX_HI  = 12;
   localparam int RX_LO  = 10;
   localparam int RY_HI  = 9;
   localparam int RY_LO  = 7;

   typedef enum logic [1:0] {
      ST_T0 = 2'd0,
      ST_T1 = 2'd1,
      ST_T2 = 2'd2,
      ST_T3 = 2'd3
   } state_e;

   function automatic logic [1:0] alu_op_of(input logic [2:0] opc);
      logic [1:0] op;
      op = ALU_ADD;
      if (opc == OP_SUB) op = ALU_SUB;
      else if (opc == OP_NAN) op = ALU_NAND;
      return op;
   endfunction

endpackage

// File: rtl/proc_reg_decoder.sv
// rtl/proc_reg_decoder.sv - register select to one-hot enable decoder with global enable
// Purpose: turns a register index into a one-hot load/drive vector.
// Ports:
//   en_i      - when low the output is all zeros
//   sel_i     - register index
//   onehot_o  - one-hot enable vector, zero when disabled
module proc_reg_decoder #(
   parameter int NREG = 8,
   parameter int SW   = $clog2(NREG)
) (
   input  logic            en_i,
   input  logic [SW-1:0]   sel_i,
   output logic [NREG-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[sel_i] = 1'b1;
   end

endmodule

// File: rtl/proc_control_unit.sv
// rtl/proc_control_unit.sv - multi-cycle control FSM sequencing the 8-register 16-bit datapath
// Purpose: accepts one instruction per valid/ready handshake into IR and drives
// Moore control outputs decoded from state and IR for T1..T3.
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-high reset
//   iin, instr_valid   - instruction word and its valid strobe
//   instr_ready        - high while idle in T0
//   r_in, r_out        - one-hot register load / bus drive enables
//   a_in, g_in, g_out  - accumulator A load, G load, G bus drive
//   imm_out, imm_data  - immediate bus drive and zero-extended IR[9:0]
//   alu_op             - 00 add, 01 sub (A-bus), 10 nand
//   out_en             - output port captures bus
//   done, illegal      - instruction retires / unsupported opcode retires
module proc_control_unit
   import proc_pkg::*;
#(
   parameter int DW    = 16,
   parameter int IMM_W = 10,
   parameter int NREG  = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [DW-1:0]   iin,
   input  logic            instr_valid,
   output logic            instr_ready,
   output logic [NREG-1:0] r_in,
   output logic [NREG-1:0] r_out,
   output logic            a_in,
   output logic            g_in,
   output logic            g_out,
   output logic            imm_out,
   output logic [DW-1:0]   imm_data,
   output logic [1:0]      alu_op,
   output logic            out_en,
   output logic            done,
   output logic            illegal
);

   localparam int SW = $clog2(NREG);

   state_e        state_q, state_d;
   logic [DW-1:0] ir_q, ir_d;

   logic [2:0]    opc;
   logic [SW-1:0] rx, ry;

   logic          rin_en, rout_en;
   logic [SW-1:0] rin_sel, rout_sel;

   assign opc = ir_q[OPC_HI:OPC_LO];
   assign rx  = ir_q[RX_HI:RX_LO];
   assign ry  = ir_q[RY_HI:RY_LO];

   assign imm_data = {{(DW-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_T0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      instr_ready = 1'b0;
      rin_en      = 1'b0;
      rin_sel     = rx;
      rout_en     = 1'b0;
      rout_sel    = rx;
      a_in        = 1'b0;
      g_in        = 1'b0;
      g_out       = 1'b0;
      imm_out     = 1'b0;
      alu_op      = ALU_ADD;
      out_en      = 1'b0;
      done        = 1'b0;
      illegal     = 1'b0;

      unique case (state_q)
         ST_T0: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               ir_d    = iin;
               state_d = ST_T1;
            end
         end
         ST_T1: begin
            state_d = ST_T0;
            case (opc)
               OP_LDI: begin
                  imm_out = 1'b1;
                  rin_en  = 1'b1;
                  done    = 1'b1;
               end
               OP_REP: begin
                  rout_en  = 1'b1;
                  rout_sel = ry;
                  rin_en   = 1'b1;
                  done     = 1'b1;
               end
               OP_OUT: begin
                  rout_en = 1'b1;
                  out_en  = 1'b1;
                  done    = 1'b1;
               end
               OP_ADD, OP_SUB, OP_NAN: begin
                  rout_en = 1'b1;
                  a_in    = 1'b1;
                  state_d = ST_T2;
               end
               default: begin
                  illegal = 1'b1;
                  done    = 1'b1;
               end
            endcase
         end
         ST_T2: begin
            // Only ALU opcodes reach T2, so ry and the ALU select are always meaningful here.
            rout_en  = 1'b1;
            rout_sel = ry;
            g_in     = 1'b1;
            alu_op   = alu_op_of(opc);
            state_d  = ST_T3;
         end
         ST_T3: begin
            g_out   = 1'b1;
            rin_en  = 1'b1;
            done    = 1'b1;
            state_d = ST_T0;
         end
         default: state_d = ST_T0;
      endcase
   end

   proc_reg_decoder #(.NREG(NREG), .SW(SW)) u_rin_dec (
      .en_i     (rin_en),
      .sel_i    (rin_sel),
      .onehot_o (r_in)
   );

   proc_reg_decoder #(.NREG(NREG), .SW(SW)) u_rout_dec (
      .en_i     (rout_en),
      .sel_i    (rout_sel),
      .onehot_o (r_out)
   );

endmodule

// File: tb/tb_proc_control_unit.sv
// tb/tb_proc_control_unit.sv - randomized self-checking bench for proc_control_unit
module tb_proc_control_unit;
   import proc_pkg::*;

   logic        clock;
   logic        reset;
   logic [15:0] iin;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  r_in;
   logic [7:0]  r_out;
   logic        a_in, g_in, g_out, imm_out;
   logic [15:0] imm_data;
   logic [1:0]  alu_op;
   logic        out_en, done, illegal;

   proc_control_unit #(.DW(16), .IMM_W(10), .NREG(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .iin         (iin),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .r_in        (r_in),
      .r_out       (r_out),
      .a_in        (a_in),
      .g_in        (g_in),
      .g_out       (g_out),
      .imm_out     (imm_out),
      .imm_data    (imm_data),
      .alu_op      (alu_op),
      .out_en      (out_en),
      .done        (done),
      .illegal     (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic       rdy;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       a_in;
      logic       g_in;
      logic       g_out;
      logic       imm_out;
      logic [1:0] alu;
      logic       out_en;
      logic       done;
      logic       ill;
   } ctl_t;

   ctl_t        exp_q[$];
   logic [15:0] ir_m;
   int          checks;
   int          errors;

   logic [15:0] rf[8];
   logic [15:0] a_r, g_r, last_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected per-cycle control steps of one instruction, in execution order.
   task automatic push_instr(input logic [15:0] w);
      ctl_t       c;
      logic [2:0] opc;
      logic [7:0] mx, my;
      opc = w[15:13];
      mx  = 8'd1 << w[12:10];
      my  = 8'd1 << w[9:7];
      c   = '0;
      if (opc == OP_LDI) begin
         c.imm_out = 1; c.rin = mx; c.done = 1; exp_q.push_back(c);
      end else if (opc == OP_REP) begin
         c.rout = my; c.rin = mx; c.done = 1; exp_q.push_back(c);
      end else if (opc == OP_OUT) begin
         c.rout = mx; c.out_en = 1; c.done = 1; exp_q.push_back(c);
      end else if (opc == OP_ADD || opc == OP_SUB || opc == OP_NAN) begin
         c.rout = mx; c.a_in = 1; exp_q.push_back(c);
         c = '0;
         c.rout = my; c.g_in = 1;
         c.alu = (opc == OP_ADD) ? 2'b00 : (opc == OP_SUB) ? 2'b01 : 2'b10;
         exp_q.push_back(c);
         c = '0;
         c.g_out = 1; c.rin = mx; c.done = 1; exp_q.push_back(c);
      end else begin
         c.ill = 1; c.done = 1; exp_q.push_back(c);
      end
   endtask

   task automatic cyc(input logic r, input logic v, input logic [15:0] w);
      ctl_t        e;
      logic [15:0] bus;
      reset       = r;
      instr_valid = v;
      iin         = w;
      @(posedge clock);
      if (r) begin
         exp_q.delete();
         ir_m = '0;
      end else if (exp_q.size() > 0) begin
         void'(exp_q.pop_front());
      end else if (v) begin
         ir_m = w;
         push_instr(w);
      end
      #2;
      e = '0;
      if (exp_q.size() > 0) e = exp_q[0];
      else e.rdy = 1'b1;
      chk("instr_ready", instr_ready, e.rdy);
      chk("r_in", r_in, e.rin);
      chk("r_out", r_out, e.rout);
      chk("a_in", a_in, e.a_in);
      chk("g_in", g_in, e.g_in);
      chk("g_out", g_out, e.g_out);
      chk("imm_out", imm_out, e.imm_out);
      chk("alu_op", alu_op, e.alu);
      chk("out_en", out_en, e.out_en);
      chk("done", done, e.done);
      chk("illegal", illegal, e.ill);
      chk("imm_data", imm_data, {6'd0, ir_m[9:0]});
      chk("bus_exclusive", ($countones(r_out) + int'(g_out) + int'(imm_out)) <= 1, 1);
      chk("r_in_onehot", $countones(r_in) <= 1, 1);
      // Small datapath driven by the DUT's control outputs; writes land at the coming edge.
      bus = '0;
      for (int i = 0; i < 8; i++) if (r_out[i]) bus |= rf[i];
      if (g_out) bus |= g_r;
      if (imm_out) bus |= imm_data;
      if (g_in) begin
         if (alu_op == 2'b00) g_r = a_r + bus;
         else if (alu_op == 2'b01) g_r = a_r - bus;
         else g_r = ~(a_r & bus);
      end
      if (a_in) a_r = bus;
      for (int i = 0; i < 8; i++) if (r_in[i]) rf[i] = bus;
      if (out_en) last_out = bus;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ir_m = '0;
      a_r = '0; g_r = '0; last_out = '0;
      for (int i = 0; i < 8; i++) rf[i] = '0;

      cyc(1, 0, 16'h0);
      cyc(1, 0, 16'h0);
      cyc(0, 0, 16'h0);
      chk("lit_reset_ready", instr_ready, 1);
      chk("lit_reset_rin", r_in, 0);
      cyc(0, 0, 16'h0);
      chk("lit_idle_ready", instr_ready, 1);

      cyc(0, 1, 16'b101_000_0000011100);
      chk("lit_ldi_imm_out", imm_out, 1);
      chk("lit_ldi_rin", r_in, 8'h01);
      chk("lit_ldi_imm_data", imm_data, 16'd28);
      chk("lit_ldi_done", done, 1);
      chk("lit_ldi_busy", instr_ready, 0);
      cyc(0, 0, 16'h0);
      chk("lit_ldi_ready_back", instr_ready, 1);

      cyc(0, 1, 16'b101_001_0000001010);
      cyc(0, 0, 16'h0);
      cyc(0, 1, 16'b001_000_001_0000000);
      chk("lit_sub_t1_rout", r_out, 8'h01);
      chk("lit_sub_t1_a_in", a_in, 1);
      cyc(0, 1, 16'hFFFF);
      chk("lit_sub_t2_rout", r_out, 8'h02);
      chk("lit_sub_t2_alu", alu_op, 2'b01);
      cyc(0, 1, 16'h1234);
      chk("lit_sub_t3_g_out", g_out, 1);
      chk("lit_sub_t3_done", done, 1);
      chk("lit_sub_r0", rf[0], 16'd18);
      cyc(0, 0, 16'h0);

      cyc(0, 1, 16'b100_000_0000000000);
      chk("lit_out_rout", r_out, 8'h01);
      chk("lit_out_en", out_en, 1);
      chk("lit_out_bus", last_out, 16'd18);
      cyc(0, 0, 16'h0);

      cyc(0, 1, 16'b011_000_0000000000);
      chk("lit_ill_illegal", illegal, 1);
      chk("lit_ill_done", done, 1);
      chk("lit_ill_rout", r_out, 0);
      cyc(0, 0, 16'h0);
      cyc(0, 1, 16'b101_010_0000000101);
      chk("lit_ldi2_rin", r_in, 8'h04);
      cyc(0, 0, 16'h0);

      cyc(0, 1, 16'b000_011_100_0000000);
      cyc(0, 1, 16'hABCD);
      chk("lit_add_t2_g_in", g_in, 1);
      cyc(1, 1, 16'h5555);
      chk("lit_abort_done", done, 0);
      chk("lit_abort_ready", instr_ready, 1);
      cyc(0, 0, 16'h0);

      for (int n = 0; n < 600; n++) begin
         logic [31:0] rnd;
         rnd = $urandom;
         cyc($urandom_range(0, 59) == 0, rnd[16], rnd[15:0]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
